// File: rtl/rob_pkg.sv
// Shared ROB types and scheduler constants: issue/writeback records,
// completion status codes, execution-lane indices and the default timeout.
package rob_pkg;

    localparam int ROB_ENTRIES   = 16;
    localparam int ROB_PTR_W     = $clog2(ROB_ENTRIES);
    localparam int NUM_LANES     = 4;
    localparam int SCHED_TIMEOUT = 255;

    localparam int LANE_ALU = 0;
    localparam int LANE_FPU = 1;
    localparam int LANE_LSU = 2;
    localparam int LANE_BRU = 3;

    typedef enum logic [1:0] {
        DONE      = 2'd0,
        EXCEPTION = 2'd1,
        INTERRUPT = 2'd2,
        TRAP      = 2'd3
    } rob_status;

    typedef struct packed {
        logic                 valid;
        logic [ROB_PTR_W-1:0] ptr;
        logic [7:0]           opcode;
    } rob_uop;

    typedef struct packed {
        rob_uop uop;
    } rob_issue;

    typedef struct packed {
        logic                 valid;
        logic [ROB_PTR_W-1:0] ptr;
        rob_status            status;
    } rob_writeback;

endpackage

// File: rtl/insn_scheduler_if.sv
// Scheduler bus: ROB-facing issue/ready/writeback plus the execution-unit
// request/done handshake. slave = scheduler side, master = ROB/units side.
interface insn_scheduler_if;
    import rob_pkg::*;

    logic                    flush_in;
    rob_issue     [3:0]      issue_in;
    logic         [3:0]      unit_ready_out;
    rob_issue     [3:0]      req_out;
    logic         [3:0]      req_valid_out;
    logic         [3:0]      req_ready_in;
    logic         [3:0]      done_valid_in;
    rob_status    [3:0]      done_status_in;
    rob_writeback [3:0]      writeback_out;

    modport slave (
        input  flush_in,
        input  issue_in,
        output unit_ready_out,
        output req_out,
        output req_valid_out,
        input  req_ready_in,
        input  done_valid_in,
        input  done_status_in,
        output writeback_out
    );

    modport master (
        output flush_in,
        output issue_in,
        input  unit_ready_out,
        input  req_out,
        input  req_valid_out,
        output req_ready_in,
        output done_valid_in,
        output done_status_in,
        input  writeback_out
    );

endinterface

// File: rtl/insn_scheduler_lane.sv
// One execution-unit lane: IDLE -> HELD -> BUSY -> IDLE with a busy-cycle
// watchdog. The writeback it produces is combinational for the cycle in
// which the op finishes; the top registers and compacts it.
module sched_lane
    import rob_pkg::*;
#(
    parameter int TIMEOUT = SCHED_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  rob_issue     i_issue,
    output logic         o_ready,
    output rob_issue     o_req,
    output logic         o_req_valid,
    input  logic         i_req_ready,
    input  logic         i_done_valid,
    input  rob_status    i_done_status,
    output rob_writeback o_wb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_BUSY = 2'd2
    } lane_state_t;

    // Counter value seen in the TIMEOUT-th busy cycle (counter starts at 0).
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lane_state_t r_state;
    rob_issue    r_op;
    logic [7:0]  r_cnt;
    logic        r_req_valid;
    logic        w_finish;

    // Op leaves BUSY this cycle, either by completion or by watchdog expiry.
    assign w_finish = (r_state == S_BUSY) &&
                      (i_done_valid || (r_cnt == TIMEOUT_LAST));

    // Ready is gated by reset so the ROB sees 0 while reset is held.
    assign o_ready     = (r_state == S_IDLE) && !i_flush && !i_rst;
    assign o_req       = r_op;
    assign o_req_valid = r_req_valid;

    // Lane FSM, captured op, busy counter and request-valid register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_cnt       <= 8'd0;
            r_req_valid <= 1'b0;
        end else if (i_flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_issue.uop.valid) begin
                        r_op        <= i_issue;
                        r_req_valid <= 1'b1;
                        r_state     <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (i_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= 8'd0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_finish) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= 8'd0;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion record; a real done wins over a same-cycle watchdog expiry.
    always_comb begin
        o_wb = '0;
        if (w_finish && !i_flush) begin
            o_wb.valid  = 1'b1;
            o_wb.ptr    = r_op.uop.ptr;
            o_wb.status = i_done_valid ? i_done_status : EXCEPTION;
        end else begin
            o_wb = '0;
        end
    end

endmodule

// File: rtl/insn_scheduler.sv
// Instruction scheduler: four independent unit lanes (ALU, FPU, LSU, BRU)
// between the ROB issue port and the execution units, with completions
// registered and packed into the lowest writeback lanes in unit order.
module insn_scheduler
    import rob_pkg::*;
#(
    parameter int Q_DEPTH = ROB_ENTRIES,
    parameter int TIMEOUT = SCHED_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    insn_scheduler_if.slave  bus
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    // A ROB shallower than the package maximum only uses the low ptr bits.
    localparam logic [ROB_PTR_W-1:0] PTR_MASK = ROB_PTR_W'((1 << PTR_W) - 1);

    logic         [3:0] w_ready;
    rob_issue     [3:0] w_req;
    logic         [3:0] w_req_valid;
    rob_writeback [3:0] w_lane_wb;
    rob_writeback [3:0] w_comp;
    rob_writeback       w_entry;
    logic         [2:0] w_k;
    rob_writeback [3:0] r_wb;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sched_lane #(
            .TIMEOUT (TIMEOUT)
        ) u_lane (
            .i_clk         (clk_in),
            .i_rst         (rst_in),
            .i_flush       (bus.flush_in),
            .i_issue       (bus.issue_in[g]),
            .o_ready       (w_ready[g]),
            .o_req         (w_req[g]),
            .o_req_valid   (w_req_valid[g]),
            .i_req_ready   (bus.req_ready_in[g]),
            .i_done_valid  (bus.done_valid_in[g]),
            .i_done_status (bus.done_status_in[g]),
            .o_wb          (w_lane_wb[g])
        );
    end

    assign bus.unit_ready_out = w_ready;
    assign bus.req_out        = w_req;
    assign bus.req_valid_out  = w_req_valid;
    assign bus.writeback_out  = r_wb;

    // Pack this cycle's lane completions into the lowest slots, ALU first.
    always_comb begin
        w_comp  = '0;
        w_entry = '0;
        w_k     = 3'd0;
        for (int u = 0; u < NUM_LANES; u++) begin
            if (w_lane_wb[u].valid) begin
                w_entry          = w_lane_wb[u];
                w_entry.ptr      = w_lane_wb[u].ptr & PTR_MASK;
                w_comp[w_k[1:0]] = w_entry;
                w_k              = w_k + 3'd1;
            end else begin
                w_k = w_k;
            end
        end
    end

    // Registered writeback port; a flush cycle yields an all-invalid word.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wb <= '0;
        end else if (bus.flush_in) begin
            r_wb <= '0;
        end else begin
            r_wb <= w_comp;
        end
    end

endmodule

// File: tb/tb_insn_scheduler.sv
// Directed bench for insn_scheduler: one task per scenario, inline checks.
module tb_insn_scheduler;
    import rob_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    insn_scheduler_if sif ();

    insn_scheduler #(
        .Q_DEPTH (ROB_ENTRIES),
        .TIMEOUT (255)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rob_issue mk_issue(input logic [3:0] ptr);
        rob_issue x;
        x            = '0;
        x.uop.valid  = 1'b1;
        x.uop.ptr    = ptr;
        x.uop.opcode = {4'hA, ptr};
        return x;
    endfunction

    function automatic rob_writeback mk_wb(input logic [3:0] ptr, input rob_status st);
        rob_writeback w;
        w.valid  = 1'b1;
        w.ptr    = ptr;
        w.status = st;
        return w;
    endfunction

    task automatic clr_inputs();
        sif.flush_in       = 1'b0;
        sif.issue_in       = '0;
        sif.req_ready_in   = 4'b0000;
        sif.done_valid_in  = 4'b0000;
        sif.done_status_in = {DONE, DONE, DONE, DONE};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_inputs();
        sif.issue_in[LANE_ALU] = mk_issue(4'd3);
        @(negedge clk);
        checks++;
        if (sif.unit_ready_out !== 4'b0000) begin
            failures++; $display("FAIL reset_ready: got %b want 0000", sif.unit_ready_out);
        end
        checks++;
        if (sif.req_valid_out !== 4'b0000) begin
            failures++; $display("FAIL reset_req_valid: got %b want 0000", sif.req_valid_out);
        end
        checks++;
        if (sif.writeback_out !== '0) begin
            failures++; $display("FAIL reset_wb: got %h want 0", sif.writeback_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_inputs();
        @(negedge clk);
        checks++;
        if (sif.unit_ready_out !== 4'b1111) begin
            failures++; $display("FAIL post_reset_ready: got %b want 1111", sif.unit_ready_out);
        end
        step();
    endtask

    task automatic test_alu_basic();
        rob_writeback [3:0] exp;
        // cycle 0: issue ptr 5 on ALU
        sif.issue_in[LANE_ALU] = mk_issue(4'd5);
        @(negedge clk);
        checks++;
        if (sif.unit_ready_out[LANE_ALU] !== 1'b1) begin
            failures++; $display("FAIL alu_ready_c0: got %b want 1", sif.unit_ready_out[LANE_ALU]);
        end
        step();
        // cycle 1: HELD, unit accepts
        clr_inputs();
        sif.req_ready_in[LANE_ALU] = 1'b1;
        @(negedge clk);
        checks++;
        if (sif.req_valid_out !== 4'b0001) begin
            failures++; $display("FAIL alu_req_valid: got %b want 0001", sif.req_valid_out);
        end
        checks++;
        if (sif.req_out[LANE_ALU].uop.ptr !== 4'd5) begin
            failures++; $display("FAIL alu_req_ptr: got %0d want 5", sif.req_out[LANE_ALU].uop.ptr);
        end
        checks++;
        if (sif.unit_ready_out[LANE_ALU] !== 1'b0) begin
            failures++; $display("FAIL alu_ready_held: got %b want 0", sif.unit_ready_out[LANE_ALU]);
        end
        step();
        // cycle 2: BUSY, done arrives; lane freed but not yet ready
        clr_inputs();
        sif.done_valid_in[LANE_ALU]  = 1'b1;
        sif.done_status_in[LANE_ALU] = DONE;
        @(negedge clk);
        checks++;
        if (sif.req_valid_out !== 4'b0000) begin
            failures++; $display("FAIL alu_req_cleared: got %b want 0000", sif.req_valid_out);
        end
        checks++;
        if (sif.unit_ready_out[LANE_ALU] !== 1'b0) begin
            failures++; $display("FAIL alu_ready_done_cycle: got %b want 0", sif.unit_ready_out[LANE_ALU]);
        end
        checks++;
        if (sif.writeback_out !== '0) begin
            failures++; $display("FAIL alu_wb_early: got %h want 0", sif.writeback_out);
        end
        step();
        // cycle 3: writeback visible, lane ready again
        clr_inputs();
        exp    = '0;
        exp[0] = mk_wb(4'd5, DONE);
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== exp) begin
            failures++; $display("FAIL alu_wb: got %h want %h", sif.writeback_out, exp);
        end
        checks++;
        if (sif.unit_ready_out !== 4'b1111) begin
            failures++; $display("FAIL alu_ready_c3: got %b want 1111", sif.unit_ready_out);
        end
        step();
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== '0) begin
            failures++; $display("FAIL alu_wb_once: got %h want 0", sif.writeback_out);
        end
        step();
    endtask

    task automatic test_two_done();
        rob_writeback [3:0] exp;
        sif.issue_in[LANE_FPU] = mk_issue(4'd2);
        sif.issue_in[LANE_BRU] = mk_issue(4'd9);
        step();
        clr_inputs();
        sif.req_ready_in = 4'b1010;
        step();
        clr_inputs();
        sif.done_valid_in                = 4'b1010;
        sif.done_status_in[LANE_FPU]     = EXCEPTION;
        sif.done_status_in[LANE_BRU]     = DONE;
        step();
        clr_inputs();
        exp    = '0;
        exp[0] = mk_wb(4'd2, EXCEPTION);
        exp[1] = mk_wb(4'd9, DONE);
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== exp) begin
            failures++; $display("FAIL fpu_bru_wb: got %h want %h", sif.writeback_out, exp);
        end
        step();
    endtask

    task automatic test_three_done();
        rob_writeback [3:0] exp;
        sif.issue_in[LANE_ALU] = mk_issue(4'd12);
        sif.issue_in[LANE_LSU] = mk_issue(4'd0);
        sif.issue_in[LANE_BRU] = mk_issue(4'd15);
        step();
        clr_inputs();
        sif.req_ready_in = 4'b1101;
        step();
        clr_inputs();
        sif.done_valid_in            = 4'b1101;
        sif.done_status_in[LANE_ALU] = INTERRUPT;
        sif.done_status_in[LANE_LSU] = TRAP;
        sif.done_status_in[LANE_BRU] = DONE;
        step();
        clr_inputs();
        exp    = '0;
        exp[0] = mk_wb(4'd12, INTERRUPT);
        exp[1] = mk_wb(4'd0, TRAP);
        exp[2] = mk_wb(4'd15, DONE);
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== exp) begin
            failures++; $display("FAIL three_wb: got %h want %h", sif.writeback_out, exp);
        end
        step();
    endtask

    task automatic test_lsu_hold();
        rob_writeback [3:0] exp;
        sif.issue_in[LANE_LSU] = mk_issue(4'd7);
        step();
        clr_inputs();
        // done while HELD must be ignored
        sif.done_valid_in[LANE_LSU] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sif.req_valid_out[LANE_LSU] !== 1'b1) begin
                failures++; $display("FAIL lsu_hold_valid c%0d: got %b want 1", i, sif.req_valid_out[LANE_LSU]);
            end
            checks++;
            if (sif.unit_ready_out[LANE_LSU] !== 1'b0) begin
                failures++; $display("FAIL lsu_hold_ready c%0d: got %b want 0", i, sif.unit_ready_out[LANE_LSU]);
            end
            checks++;
            if (sif.writeback_out !== '0) begin
                failures++; $display("FAIL lsu_hold_wb c%0d: got %h want 0", i, sif.writeback_out);
            end
            step();
        end
        checks++;
        if (sif.req_out[LANE_LSU].uop.ptr !== 4'd7) begin
            failures++; $display("FAIL lsu_req_ptr: got %0d want 7", sif.req_out[LANE_LSU].uop.ptr);
        end
        clr_inputs();
        sif.req_ready_in[LANE_LSU] = 1'b1;
        step();
        clr_inputs();
        sif.done_valid_in[LANE_LSU] = 1'b1;
        step();
        clr_inputs();
        exp    = '0;
        exp[0] = mk_wb(4'd7, DONE);
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== exp) begin
            failures++; $display("FAIL lsu_wb: got %h want %h", sif.writeback_out, exp);
        end
        step();
    endtask

    task automatic test_timeout();
        rob_writeback [3:0] exp;
        int early_wb;
        early_wb = 0;
        sif.issue_in[LANE_ALU] = mk_issue(4'd11);
        step();
        clr_inputs();
        sif.req_ready_in[LANE_ALU] = 1'b1;
        step();
        clr_inputs();
        // 255 BUSY cycles with no done
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (sif.writeback_out !== '0 || sif.unit_ready_out[LANE_ALU] !== 1'b0) begin
                early_wb++;
            end
            step();
        end
        checks++;
        if (early_wb !== 0) begin
            failures++; $display("FAIL timeout_early: got %0d bad busy cycles want 0", early_wb);
        end
        exp    = '0;
        exp[0] = mk_wb(4'd11, EXCEPTION);
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== exp) begin
            failures++; $display("FAIL timeout_wb: got %h want %h", sif.writeback_out, exp);
        end
        checks++;
        if (sif.unit_ready_out[LANE_ALU] !== 1'b1) begin
            failures++; $display("FAIL timeout_ready: got %b want 1", sif.unit_ready_out[LANE_ALU]);
        end
        step();
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== '0) begin
            failures++; $display("FAIL timeout_wb_once: got %h want 0", sif.writeback_out);
        end
        step();
    endtask

    task automatic test_flush();
        sif.issue_in[LANE_ALU] = mk_issue(4'd1);
        sif.issue_in[LANE_FPU] = mk_issue(4'd3);
        sif.issue_in[LANE_LSU] = mk_issue(4'd4);
        sif.issue_in[LANE_BRU] = mk_issue(4'd6);
        step();
        clr_inputs();
        sif.req_ready_in = 4'b1111;
        @(negedge clk);
        checks++;
        if (sif.req_valid_out !== 4'b1111) begin
            failures++; $display("FAIL flush_req_valid: got %b want 1111", sif.req_valid_out);
        end
        step();
        clr_inputs();
        sif.flush_in      = 1'b1;
        sif.done_valid_in = 4'b1111;
        sif.issue_in[LANE_ALU] = mk_issue(4'd8);
        @(negedge clk);
        checks++;
        if (sif.unit_ready_out !== 4'b0000) begin
            failures++; $display("FAIL flush_ready_low: got %b want 0000", sif.unit_ready_out);
        end
        step();
        clr_inputs();
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== '0) begin
            failures++; $display("FAIL flush_wb: got %h want 0", sif.writeback_out);
        end
        checks++;
        if (sif.unit_ready_out !== 4'b1111) begin
            failures++; $display("FAIL flush_ready: got %b want 1111", sif.unit_ready_out);
        end
        checks++;
        if (sif.req_valid_out !== 4'b0000) begin
            failures++; $display("FAIL flush_req_dropped: got %b want 0000", sif.req_valid_out);
        end
        step();
        @(negedge clk);
        checks++;
        if (sif.writeback_out !== '0) begin
            failures++; $display("FAIL flush_wb_after: got %h want 0", sif.writeback_out);
        end
        step();
    endtask

    task automatic test_reset_mid_held();
        sif.issue_in[LANE_BRU] = mk_issue(4'd13);
        step();
        clr_inputs();
        #1;
        checks++;
        if (sif.req_valid_out[LANE_BRU] !== 1'b1) begin
            failures++; $display("FAIL rst_held_valid: got %b want 1", sif.req_valid_out[LANE_BRU]);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (sif.req_valid_out !== 4'b0000) begin
            failures++; $display("FAIL rst_req_drop: got %b want 0000", sif.req_valid_out);
        end
        checks++;
        if (sif.unit_ready_out !== 4'b0000) begin
            failures++; $display("FAIL rst_ready_low: got %b want 0000", sif.unit_ready_out);
        end
        step();
        rst = 1'b0;
        sif.req_ready_in  = 4'b1111;
        sif.done_valid_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sif.writeback_out !== '0) begin
                failures++; $display("FAIL rst_no_wb c%0d: got %h want 0", i, sif.writeback_out);
            end
            checks++;
            if (sif.req_valid_out !== 4'b0000) begin
                failures++; $display("FAIL rst_no_req c%0d: got %b want 0000", i, sif.req_valid_out);
            end
            step();
        end
        clr_inputs();
        @(negedge clk);
        checks++;
        if (sif.unit_ready_out !== 4'b1111) begin
            failures++; $display("FAIL rst_release_ready: got %b want 1111", sif.unit_ready_out);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clr_inputs();
        test_reset();
        test_alu_basic();
        test_two_done();
        test_three_done();
        test_lsu_hold();
        test_timeout();
        test_flush();
        test_reset_mid_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
